// File: rtl/irq_pending_ctrl.sv
// Avalon-MM interrupt aggregator: edge/level pending capture, masking, combined irq and lowest-active-ID.
// Optional macro IRQ_PENDING_SYNC_EN adds a 2-flop synchronizer on every irq_in bit.
module irq_pending_ctrl #(
    parameter int unsigned NUM_IRQ    = 8,
    parameter logic [15:0] EDGE_RESET = 16'h0000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ID_W   = 4;

    localparam logic [2:0] ADDR_RAW       = 3'd0;
    localparam logic [2:0] ADDR_PENDING   = 3'd1;
    localparam logic [2:0] ADDR_MASK      = 3'd2;
    localparam logic [2:0] ADDR_ACTIVE_ID = 3'd3;
    localparam logic [2:0] ADDR_EDGE_SEL  = 3'd4;

    logic [NUM_IRQ-1:0] s;
    logic [NUM_IRQ-1:0] s_d;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] edge_sel;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] w1c;
    logic [NUM_IRQ-1:0] masked;
    logic [NUM_IRQ-1:0] pending_nxt;
    logic               wr_en;
    logic               active_valid;
    logic [ID_W-1:0]    active_id;
    logic [DATA_W-1:0]  read_mux;

    // Upper writedata bits are architecturally ignored when NUM_IRQ < 16.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    // Zero-extend an IRQ-wide vector onto the 16-bit register bus.
    function automatic logic [DATA_W-1:0] zext(input logic [NUM_IRQ-1:0] v);
        logic [DATA_W-1:0] r;
        r = '0;
        r[NUM_IRQ-1:0] = v;
        return r;
    endfunction

`ifdef IRQ_PENDING_SYNC_EN
    logic [NUM_IRQ-1:0] sync_q1;
    logic [NUM_IRQ-1:0] sync_q2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq_in;
            sync_q2 <= sync_q1;
        end
    end

    assign s = sync_q2;
`else
    assign s = irq_in;
`endif

    assign wr_en  = chipselect && !write_n;
    assign rise   = s & ~s_d;
    assign w1c    = (wr_en && (address == ADDR_PENDING)) ? writedata[NUM_IRQ-1:0] : '0;
    assign masked = pending & mask;

    // Edge bits: a same-cycle rise wins over W1C. Level bits track s and ignore W1C.
    always_comb begin
        pending_nxt = '0;
        pending_nxt = (edge_sel & (rise | (pending & ~w1c))) | (~edge_sel & s);
    end

    // Priority encoder: scan high to low so the lowest active index is left standing.
    always_comb begin
        active_valid = 1'b0;
        active_id    = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (masked[i]) begin
                active_valid = 1'b1;
                active_id    = ID_W'(i);
            end
        end
    end

    always_comb begin
        read_mux = '0;
        case (address)
            ADDR_RAW:       read_mux = zext(s);
            ADDR_PENDING:   read_mux = zext(pending);
            ADDR_MASK:      read_mux = zext(mask);
            ADDR_ACTIVE_ID: read_mux = {active_valid, (DATA_W - ID_W - 1)'(0), active_id};
            ADDR_EDGE_SEL:  read_mux = zext(edge_sel);
            default:        read_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_d     <= '0;
            pending <= '0;
        end else begin
            s_d     <= s;
            pending <= pending_nxt;
        end
    end

    // Configuration registers; only the implemented IRQ bits are stored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask     <= '0;
            edge_sel <= EDGE_RESET[NUM_IRQ-1:0];
        end else if (wr_en) begin
            if (address == ADDR_MASK) begin
                mask <= writedata[NUM_IRQ-1:0];
            end
            if (address == ADDR_EDGE_SEL) begin
                edge_sel <= writedata[NUM_IRQ-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            readdata <= read_mux;
            irq      <= |masked;
        end
    end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed, table-driven bench for irq_pending_ctrl (NUM_IRQ=8, EDGE_RESET=0, default build).
module tb_irq_pending_ctrl;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic [7:0]  irq_in;
    logic        irq;

    int errors = 0;
    int checks = 0;

    irq_pending_ctrl #(
        .NUM_IRQ    (8),
        .EDGE_RESET (16'h0000)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_in     (irq_in),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  addr;
        logic        cs;
        logic        wn;
        logic [15:0] wdata;
        logic [7:0]  in;
        logic [15:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    function automatic void v(input logic [2:0] a, input logic c, input logic w,
                              input logic [15:0] d, input logic [7:0] i,
                              input logic [15:0] erd, input logic eirq);
        vec_t t;
        t.addr = a; t.cs = c; t.wn = w; t.wdata = d; t.in = i;
        t.exp_rd = erd; t.exp_irq = eirq;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus cycle: drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic [2:0] a, input logic c, input logic w,
                        input logic [15:0] d, input logic [7:0] i);
        @(negedge clk);
        address = a; chipselect = c; write_n = w; writedata = d; irq_in = i;
        @(posedge clk);
        #1;
    endtask

    initial begin
        address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 16'h0; irq_in = 8'h0;
        reset_n = 1'b0;

        // addr, cs, wn, wdata, irq_in, expected readdata, expected irq
        v(3'd2, 1, 1, 16'h0000, 8'h00, 16'h0000, 0);  // MASK reset
        v(3'd4, 1, 1, 16'h0000, 8'h00, 16'h0000, 0);  // EDGE_SEL reset
        v(3'd4, 1, 0, 16'h0001, 8'h00, 16'h0000, 0);
        v(3'd2, 1, 0, 16'h0001, 8'h00, 16'h0000, 0);
        v(3'd2, 1, 1, 16'h0000, 8'h01, 16'h0001, 0);  // one-clock pulse on bit 0
        v(3'd1, 1, 1, 16'h0000, 8'h00, 16'h0001, 1);
        v(3'd3, 1, 1, 16'h0000, 8'h00, 16'h8000, 1);
        v(3'd1, 1, 0, 16'h0001, 8'h00, 16'h0001, 1);  // W1C bit 0
        v(3'd1, 1, 1, 16'h0000, 8'h00, 16'h0000, 0);
        v(3'd4, 1, 0, 16'h0005, 8'h00, 16'h0001, 0);
        v(3'd1, 1, 0, 16'h0004, 8'h04, 16'h0000, 0);  // edge and W1C collide on bit 2
        v(3'd1, 1, 1, 16'h0000, 8'h04, 16'h0004, 0);
        v(3'd1, 1, 0, 16'h0004, 8'h04, 16'h0004, 0);  // W1C with source still high
        v(3'd1, 1, 1, 16'h0000, 8'h00, 16'h0000, 0);
        v(3'd2, 1, 0, 16'h0006, 8'h02, 16'h0001, 0);  // level bit 1 held high
        v(3'd1, 1, 0, 16'h0002, 8'h02, 16'h0002, 1);  // W1C on level bit ignored
        v(3'd1, 1, 1, 16'h0000, 8'h02, 16'h0002, 1);
        v(3'd1, 1, 1, 16'h0000, 8'h00, 16'h0002, 1);
        v(3'd1, 1, 1, 16'h0000, 8'h00, 16'h0000, 0);
        v(3'd4, 1, 0, 16'h0015, 8'h00, 16'h0005, 0);
        v(3'd2, 1, 0, 16'h0010, 8'h14, 16'h0006, 0);
        v(3'd3, 1, 1, 16'h0000, 8'h14, 16'h8004, 1);
        v(3'd2, 1, 0, 16'h0014, 8'h00, 16'h0010, 1);
        v(3'd3, 1, 1, 16'h0000, 8'h00, 16'h8002, 1);
        v(3'd2, 1, 0, 16'h0000, 8'h00, 16'h0014, 1);
        v(3'd3, 1, 1, 16'h0000, 8'h00, 16'h0000, 0);
        v(3'd1, 1, 1, 16'h0000, 8'h00, 16'h0014, 0);
        v(3'd6, 1, 0, 16'hFFFF, 8'h00, 16'h0000, 0);  // unmapped address
        v(3'd2, 0, 0, 16'h00FF, 8'h00, 16'h0000, 0);  // no chipselect: write ignored
        v(3'd2, 1, 1, 16'h0000, 8'h00, 16'h0000, 0);
        v(3'd4, 1, 0, 16'h00FF, 8'h00, 16'h0015, 0);
        v(3'd2, 1, 0, 16'h00FF, 8'hFF, 16'h0000, 0);
        v(3'd1, 1, 1, 16'h0000, 8'hFF, 16'h00FF, 1);

        repeat (2) @(posedge clk);
        #1;
        chk("reset readdata", readdata, 16'h0000);
        chk("reset irq", 16'(irq), 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;

        for (int n = 0; n < vecs.size(); n++) begin
            step(vecs[n].addr, vecs[n].cs, vecs[n].wn, vecs[n].wdata, vecs[n].in);
            chk($sformatf("row%0d readdata", n), readdata, vecs[n].exp_rd);
            chk($sformatf("row%0d irq", n), 16'(irq), 16'(vecs[n].exp_irq));
        end

        // Asynchronous reset in the middle of a clock phase with everything pending.
        @(negedge clk);
        address = 3'd1; chipselect = 1'b1; write_n = 1'b1; writedata = 16'h0; irq_in = 8'h00;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async rst irq", 16'(irq), 16'h0000);
        chk("async rst readdata", readdata, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        step(3'd1, 1, 1, 16'h0000, 8'h00);
        chk("post rst pending", readdata, 16'h0000);
        chk("post rst irq0", 16'(irq), 16'h0000);
        step(3'd2, 1, 1, 16'h0000, 8'h00);
        chk("post rst mask", readdata, 16'h0000);
        step(3'd4, 1, 1, 16'h0000, 8'h00);
        chk("post rst edge_sel", readdata, 16'h0000);
        chk("post rst irq1", 16'(irq), 16'h0000);

        // A fresh edge after reset raises irq two clocks after it is presented.
        step(3'd4, 1, 0, 16'h0001, 8'h00);
        step(3'd2, 1, 0, 16'h0001, 8'h00);
        step(3'd1, 1, 1, 16'h0000, 8'h01);
        chk("new edge irq lat1", 16'(irq), 16'h0000);
        step(3'd1, 1, 1, 16'h0000, 8'h00);
        chk("new edge pending", readdata, 16'h0001);
        chk("new edge irq lat2", 16'(irq), 16'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
